gcd_iter: RTL and testbench

GCD_ITER -- requirements
Module: gcd_iter

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_step.sv | 48 ++++
 rtl/gcd_iter.sv | 103 ++++++++++
 tb/tb_gcd_iter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the iterative binary GCD block: FSM state encoding
// and the default operand width.
package gcd_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_step.sv
// One combinational step of the binary (Stein) GCD reduction. When either
// operand has reached zero, finish is raised and result holds the GCD.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] x_nxt,
  output logic [WIDTH-1:0] y_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             finish,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    x_nxt  = x;
    y_nxt  = y;
    k_nxt  = k;
    finish = 1'b0;
    result = '0;
    if (x == '0) begin
      finish = 1'b1;
      result = y << k;
    end else if (y == '0) begin
      finish = 1'b1;
      result = x << k;
    end else if (!x[0] && !y[0]) begin
      // common factor of two: remember it in k, restored by the final shift
      x_nxt = x >> 1;
      y_nxt = y >> 1;
      k_nxt = k + KW'(1);
    end else if (!x[0]) begin
      x_nxt = x >> 1;
    end else if (!y[0]) begin
      y_nxt = y >> 1;
    end else if (x >= y) begin
      // both odd, so the difference is even and halving loses nothing
      x_nxt = (x - y) >> 1;
    end else begin
      y_nxt = (y - x) >> 1;
    end
  end

endmodule

// File: rtl/gcd_iter.sv
// Iterative GCD with valid/ready handshakes on both sides; one reduction
// step per cycle, result held in DONE until the consumer takes it.
module gcd_iter
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic             zero_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds data stable while valid is high and ready is low;
  // in_ready is high only in IDLE, out_valid only in DONE.

  localparam int KW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [KW-1:0]    k;

  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [KW-1:0]    k_nxt;
  logic             finish;
  logic [WIDTH-1:0] result;

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .x      (x),
    .y      (y),
    .k      (k),
    .x_nxt  (x_nxt),
    .y_nxt  (y_nxt),
    .k_nxt  (k_nxt),
    .finish (finish),
    .result (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      k         <= '0;
      gcd       <= '0;
      zero_err  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x        <= a;
            y        <= b;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (finish) begin
            gcd       <= result;
            // only the 0/0 input pair can reach the end with both zero
            zero_err  <= (x == '0) && (y == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            x <= x_nxt;
            y <= y_nxt;
            k <= k_nxt;
          end
        end
        DONE: begin
          // returning to IDLE here; in_ready rises after this edge, so no
          // new operands can be taken on the same edge
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_iter.sv
// Scoreboard bench for gcd_iter: driver pushes expected results, a monitor
// pops them when out_valid appears; a WIDTH=16 instance covers wide operands.
module tb_gcd_iter;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  gcd;
  logic          zero_err;

  logic          in_valid2;
  logic          in_ready2;
  logic [W2-1:0] a2;
  logic [W2-1:0] b2;
  logic          out_valid2;
  logic          out_ready2;
  logic [W2-1:0] gcd2;
  logic          zero_err2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd       (gcd),
    .zero_err  (zero_err)
  );

  gcd_iter #(.WIDTH(W2)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .gcd       (gcd2),
    .zero_err  (zero_err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] p, input logic [W-1:0] q);
    logic [W-1:0] u, v, t;
    u = p;
    v = q;
    while (v != '0) begin
      t = u % v;
      u = v;
      v = t;
    end
    return u;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] exp_g, input int lat, input bit track);
    int n;
    @(posedge clk);
    #1;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for a=%0d b=%0d", av, bv);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    if (track) begin
      exp_q.push_back({(av == '0) && (bv == '0), exp_g});
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [W2-1:0] av, input logic [W2-1:0] bv, input logic [W2-1:0] exp_g);
    int lat;
    @(posedge clk);
    #1;
    a2        = av;
    b2        = bv;
    in_valid2 = 1'b1;
    @(negedge clk);
    check("w16_in_ready", in_ready2, 1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w16_gcd", gcd2, exp_g);
    check("w16_zero_err", zero_err2, 0);
    check("w16_latency_ok", lat <= 2 * W2 + 2, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit seen = 0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: gcd=%0d with empty queue", gcd);
        end else begin
          logic [W:0] e;
          int el, ac, lat;
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          ac = acc_q.pop_front();
          lat = cyc - ac;
          check("gcd", gcd, e[W-1:0]);
          check("zero_err", zero_err, e[W]);
          if (el >= 0) check("latency_exact", lat, el);
          else check("latency_bound", lat <= 2 * W + 2, 1);
        end
      end
      if (out_valid && out_ready) seen = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    a2         = '0;
    b2         = '0;
    out_ready2 = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_gcd", gcd, 0);
    check("rst_zero_err", zero_err, 0);
    @(negedge clk);
    rst = 1'b0;

    send(12, 8, 4, 6, 1);
    send(0, 9, 9, 1, 1);
    send(9, 0, 9, 1, 1);
    send(0, 0, 0, 1, 1);
    send(90, 86, 2, -1, 1);
    send(48, 12, 12, -1, 1);
    send(65, 4, 1, -1, 1);
    send(109, 91, 1, -1, 1);
    send(54, 44, 2, -1, 1);
    send(125, 6, 1, -1, 1);
    send(255, 255, 255, -1, 1);
    send(255, 1, 1, -1, 1);
    send(128, 64, 64, -1, 1);
    send(1, 128, 1, -1, 1);
    for (int i = 0; i < 120; i++) begin
      logic [W-1:0] av, bv;
      av = W'($urandom_range(0, 255));
      bv = W'($urandom_range(0, 255));
      send(av, bv, ref_gcd(av, bv), -1, 1);
    end
    wait_drain();

    // result held while the consumer stalls
    out_ready = 1'b0;
    send(200, 150, 50, -1, 1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_gcd", gcd, 50);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    wait_drain();

    // reset in the middle of a computation
    a        = 95;
    b        = 32;
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_gcd", gcd, 0);
    check("midrst_zero_err", zero_err, 0);
    @(negedge clk);
    rst = 1'b0;
    send(12, 8, 4, 6, 1);
    wait_drain();

    run16(16'd65535, 16'd255, 16'd255);
    run16(16'd1, 16'd65535, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
